// File: rtl/rc_servo_pulse_decoder_if.sv
// rtl/rc_servo_pulse_decoder_if.sv - pin and decoded-result bundle for the servo pulse decoder
//
// Purpose: groups the decoder's enable, raw pulse pin and decoded outputs so the
// decoder (slave) and its driver/consumer (master) share one port.
// Signals:
//   ena       decode enable (master -> decoder)
//   pwm_i     asynchronous servo pulse pin (master -> decoder)
//   pos_o     8-bit decoded position (decoder -> master)
//   strobe_o  1-cycle pulse when pos_o is updated by an accepted pulse
//   valid_o   high while an accepted pulse arrived within the frame timeout
//   glitch_o  1-cycle pulse when a measured pulse is rejected
interface rc_servo_pulse_decoder_if;
    logic       ena;
    logic       pwm_i;
    logic [7:0] pos_o;
    logic       strobe_o;
    logic       valid_o;
    logic       glitch_o;

    modport master (
        output ena,
        output pwm_i,
        input  pos_o,
        input  strobe_o,
        input  valid_o,
        input  glitch_o
    );

    modport slave (
        input  ena,
        input  pwm_i,
        output pos_o,
        output strobe_o,
        output valid_o,
        output glitch_o
    );
endinterface

// File: rtl/rc_servo_pulse_decoder.sv
// rtl/rc_servo_pulse_decoder.sv - hobby-servo pulse width to 8-bit position decoder
//
// Purpose: measures the high time of an asynchronous RC servo pulse in units of
// CLKS_PER_LSB clocks and maps it to position 0..255 (OFFSET_LSB -> 0, clamped).
// Pulses outside MIN_WIDTH_LSB..MAX_WIDTH_LSB are reported on glitch_o; absence of
// an accepted pulse for FRAME_TIMEOUT_LSB drops valid_o.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    rc_servo_pulse_decoder_if.slave: ena, pwm_i in; pos_o, strobe_o,
//          valid_o, glitch_o out (all outputs registered)
// Configuration macro: RC_DEC_FAILSAFE_EN - when defined, pos_o is forced to
// centre (128) in the cycle valid_o falls on timeout; otherwise pos_o holds.
module rc_servo_pulse_decoder #(
    parameter int CLKS_PER_LSB      = 39,
    parameter int OFFSET_LSB        = 256,
    parameter int MIN_WIDTH_LSB     = 128,
    parameter int MAX_WIDTH_LSB     = 768,
    parameter int FRAME_TIMEOUT_LSB = 6400
) (
    input  logic                        clk,
    input  logic                        rst_n,
    rc_servo_pulse_decoder_if.slave     bus
);

    localparam int                PW         = (CLKS_PER_LSB > 1) ? $clog2(CLKS_PER_LSB) : 1;
    localparam logic [PW-1:0]     PRESC_MAX  = PW'(CLKS_PER_LSB - 1);
    localparam logic [9:0]        MIN_W      = 10'(MIN_WIDTH_LSB);
    localparam logic [9:0]        MAX_W      = 10'(MAX_WIDTH_LSB);
    localparam logic [9:0]        WIDTH_SAT  = 10'h3FF;
    localparam logic [12:0]       TO_LIM     = 13'(FRAME_TIMEOUT_LSB);
    localparam logic [12:0]       TO_SAT     = 13'h1FFF;
    localparam logic signed [10:0] OFFSET_S  = 11'(OFFSET_LSB);

    typedef enum logic [1:0] {
        WAIT_LOW  = 2'd0,
        WAIT_RISE = 2'd1,
        MEASURE   = 2'd2
    } state_t;

    state_t            state_q;
    logic              sync1_q, sync2_q, sync3_q;
    logic [PW-1:0]     presc_q;
    logic [9:0]        width_q;
    logic [12:0]       timeout_q;
    logic [7:0]        pos_q;
    logic              strobe_q, valid_q, glitch_q;

    logic              rise, fall, tick;
    logic [9:0]        width_d;
    logic [12:0]       timeout_d;
    logic signed [10:0] diff_d;
    logic [7:0]        pos_d;
    logic              width_ok, accept, timeout_hit;

    assign rise = sync2_q & ~sync3_q;
    assign fall = ~sync2_q & sync3_q;
    assign tick = (presc_q == PRESC_MAX);

    always_comb begin
        // Width including a tick landing in the current cycle, so a fall is
        // evaluated as floor(high_clks / CLKS_PER_LSB).
        width_d = width_q;
        if (tick && (width_q != WIDTH_SAT)) begin
            width_d = width_q + 10'd1;
        end

        diff_d = $signed({1'b0, width_d}) - OFFSET_S;
        pos_d  = diff_d[7:0];
        if (diff_d[10]) begin
            pos_d = 8'd0;
        end else if (diff_d > 11'sd255) begin
            pos_d = 8'd255;
        end

        width_ok    = (width_d >= MIN_W) && (width_d <= MAX_W);
        accept      = bus.ena && (state_q == MEASURE) && fall && width_ok;
        timeout_hit = (timeout_q >= TO_LIM);

        timeout_d = timeout_q;
        if (accept) begin
            timeout_d = 13'd0;
        end else if (tick && (timeout_q != TO_SAT)) begin
            timeout_d = timeout_q + 13'd1;
        end
    end

    // Synchronizer resets high: a pin already high at release never looks like
    // a rise, and a low pin simply produces an ignored fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            sync3_q   <= 1'b1;
            presc_q   <= '0;
            timeout_q <= 13'd0;
        end else begin
            sync1_q   <= bus.pwm_i;
            sync2_q   <= sync1_q;
            sync3_q   <= sync2_q;
            presc_q   <= (rise || tick) ? '0 : presc_q + PW'(1);
            timeout_q <= timeout_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= WAIT_LOW;
            width_q  <= 10'd0;
            pos_q    <= 8'd0;
            strobe_q <= 1'b0;
            valid_q  <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            glitch_q <= 1'b0;

            if (accept) begin
                valid_q <= 1'b1;
            end else if (timeout_hit) begin
                valid_q <= 1'b0;
`ifdef RC_DEC_FAILSAFE_EN
                if (valid_q) begin
                    pos_q <= 8'd128;
                end
`endif
            end

            if (!bus.ena) begin
                state_q <= WAIT_LOW;
            end else begin
                case (state_q)
                    WAIT_LOW: begin
                        if (!sync2_q) begin
                            state_q <= WAIT_RISE;
                        end
                    end
                    WAIT_RISE: begin
                        if (rise) begin
                            state_q <= MEASURE;
                            width_q <= 10'd0;
                        end
                    end
                    MEASURE: begin
                        if (fall) begin
                            state_q <= WAIT_RISE;
                            if (width_ok) begin
                                pos_q    <= pos_d;
                                strobe_q <= 1'b1;
                            end else begin
                                glitch_q <= 1'b1;
                            end
                        end else if (width_q > MAX_W) begin
                            // Stuck high: report once, then require a low before re-arming.
                            state_q  <= WAIT_LOW;
                            glitch_q <= 1'b1;
                        end else begin
                            width_q <= width_d;
                        end
                    end
                    default: state_q <= WAIT_LOW;
                endcase
            end
        end
    end

    assign bus.pos_o    = pos_q;
    assign bus.strobe_o = strobe_q;
    assign bus.valid_o  = valid_q;
    assign bus.glitch_o = glitch_q;

endmodule

// File: tb/tb_rc_servo_pulse_decoder.sv
// tb/tb_rc_servo_pulse_decoder.sv - self-checking bench for rc_servo_pulse_decoder
`timescale 1ns/1ps
module tb_rc_servo_pulse_decoder;
    localparam int CPL  = 4;
    localparam int OFF  = 256;
    localparam int MINW = 128;
    localparam int MAXW = 768;
    localparam int TO   = 1500;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    int         last_accept_cyc = 0;
    bit         had_accept = 1'b0;
    logic [7:0] model_pos = 8'd0;

    always #50 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rc_servo_pulse_decoder_if bus ();

    rc_servo_pulse_decoder #(
        .CLKS_PER_LSB      (CPL),
        .OFFSET_LSB        (OFF),
        .MIN_WIDTH_LSB     (MINW),
        .MAX_WIDTH_LSB     (MAXW),
        .FRAME_TIMEOUT_LSB (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic void ref_decode(input int high, output bit accept, output bit short_p,
                                       output logic [7:0] pos);
        int w;
        int p;
        w = high / CPL;
        if (w > 1023) w = 1023;
        accept  = (w >= MINW) && (w <= MAXW);
        short_p = (w < MINW);
        p = w - OFF;
        if (p < 0) p = 0;
        if (p > 255) p = 255;
        pos = 8'(p);
    endfunction

    // Drives one pulse (high clks then low clks) and records what the DUT reported.
    task automatic drive_pulse(input int high, input int low,
                               output int strobe_at, output int strobe_cyc, output int n_strobe,
                               output int n_glitch, output int glitch_at,
                               output logic [7:0] pos_seen, output logic valid_seen);
        strobe_at = 0; strobe_cyc = 0; n_strobe = 0; n_glitch = 0; glitch_at = 0;
        @(posedge clk); #1;
        bus.pwm_i = 1'b1;
        for (int i = 1; i <= high; i++) begin
            @(posedge clk); #1;
            if (bus.strobe_o) n_strobe++;
            if (bus.glitch_o) n_glitch++;
        end
        bus.pwm_i = 1'b0;
        for (int i = 1; i <= low; i++) begin
            @(posedge clk); #1;
            if (bus.strobe_o) begin n_strobe++; strobe_at = i; strobe_cyc = cyc; end
            if (bus.glitch_o) begin n_glitch++; glitch_at = i; end
        end
        pos_seen   = bus.pos_o;
        valid_seen = bus.valid_o;
    endtask

    task automatic test_reset;
        bus.ena = 1'b1;
        bus.pwm_i = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (bus.pos_o !== 8'd0) $display("FAIL reset_pos: got %0d expected 0", bus.pos_o); else n_pass++;
        n_total++; if (bus.strobe_o !== 1'b0) $display("FAIL reset_strobe: got %b expected 0", bus.strobe_o); else n_pass++;
        n_total++; if (bus.valid_o !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.valid_o); else n_pass++;
        n_total++; if (bus.glitch_o !== 1'b0) $display("FAIL reset_glitch: got %b expected 0", bus.glitch_o); else n_pass++;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_nominal;
        int highs[4] = '{1538, 1025, 2051, 923};
        int sa, sc, ns, ng, ga;
        logic [7:0] ps, ep;
        logic vs;
        bit acc, sh;
        foreach (highs[k]) begin
            ref_decode(highs[k], acc, sh, ep);
            drive_pulse(highs[k], 40, sa, sc, ns, ng, ga, ps, vs);
            n_total++; if (sa !== 3) $display("FAIL nominal_latency[%0d]: got %0d expected 3", k, sa); else n_pass++;
            n_total++; if (ns !== 1) $display("FAIL nominal_strobe_count[%0d]: got %0d expected 1", k, ns); else n_pass++;
            n_total++; if (ng !== 0) $display("FAIL nominal_glitch[%0d]: got %0d expected 0", k, ng); else n_pass++;
            n_total++; if (ps !== ep) $display("FAIL nominal_pos[%0d]: got %0d expected %0d", k, ps, ep); else n_pass++;
            n_total++; if (vs !== 1'b1) $display("FAIL nominal_valid[%0d]: got %b expected 1", k, vs); else n_pass++;
            model_pos = ep; had_accept = 1'b1; last_accept_cyc = sc;
        end
    endtask

    task automatic test_boundaries;
        int highs[5] = '{MINW*CPL, MINW*CPL-1, MAXW*CPL+CPL-1, 1538, 307};
        int sa, sc, ns, ng, ga;
        logic [7:0] ps, ep;
        logic vs;
        bit acc, sh;
        foreach (highs[k]) begin
            ref_decode(highs[k], acc, sh, ep);
            drive_pulse(highs[k], 40, sa, sc, ns, ng, ga, ps, vs);
            if (acc) begin
                n_total++; if (sa !== 3 || ns !== 1 || ng !== 0) $display("FAIL bound_accept[%0d]: got strobe_at=%0d strobes=%0d glitches=%0d expected 3/1/0", k, sa, ns, ng); else n_pass++;
                model_pos = ep; had_accept = 1'b1; last_accept_cyc = sc;
            end else begin
                n_total++; if (ga !== 3 || ng !== 1 || ns !== 0) $display("FAIL bound_reject[%0d]: got glitch_at=%0d glitches=%0d strobes=%0d expected 3/1/0", k, ga, ng, ns); else n_pass++;
            end
            n_total++; if (ps !== model_pos) $display("FAIL bound_pos[%0d]: got %0d expected %0d", k, ps, model_pos); else n_pass++;
        end
    endtask

    task automatic test_stuck_high;
        int sa, sc, ns, ng, ga;
        logic [7:0] ps, ep;
        logic vs;
        bit acc, sh;
        drive_pulse(4102, 40, sa, sc, ns, ng, ga, ps, vs);
        n_total++; if (ng !== 1) $display("FAIL stuck_glitch_count: got %0d expected 1", ng); else n_pass++;
        n_total++; if (ga !== 0) $display("FAIL stuck_glitch_on_fall: got %0d expected 0", ga); else n_pass++;
        n_total++; if (ns !== 0) $display("FAIL stuck_strobe: got %0d expected 0", ns); else n_pass++;
        n_total++; if (ps !== model_pos) $display("FAIL stuck_pos: got %0d expected %0d", ps, model_pos); else n_pass++;
        ref_decode(1538, acc, sh, ep);
        drive_pulse(1538, 40, sa, sc, ns, ng, ga, ps, vs);
        n_total++; if (sa !== 3 || ps !== ep) $display("FAIL stuck_recover: got strobe_at=%0d pos=%0d expected 3/%0d", sa, ps, ep); else n_pass++;
        model_pos = ep; had_accept = 1'b1; last_accept_cyc = sc;
    endtask

    task automatic test_ena;
        int ns, ng, sa, sc, ga;
        logic [7:0] ps, ep;
        logic vs;
        bit acc, sh;
        ns = 0; ng = 0;
        @(posedge clk); #1;
        bus.pwm_i = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            if (i == 500) bus.ena = 1'b0;
            if (i == 520) bus.ena = 1'b1;
            if (bus.strobe_o) ns++;
            if (bus.glitch_o) ng++;
        end
        bus.pwm_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.strobe_o) ns++;
            if (bus.glitch_o) ng++;
        end
        n_total++; if (ns !== 0) $display("FAIL ena_strobe: got %0d expected 0", ns); else n_pass++;
        n_total++; if (ng !== 0) $display("FAIL ena_glitch: got %0d expected 0", ng); else n_pass++;
        n_total++; if (bus.pos_o !== model_pos) $display("FAIL ena_pos_hold: got %0d expected %0d", bus.pos_o, model_pos); else n_pass++;
        ref_decode(2051, acc, sh, ep);
        drive_pulse(2051, 40, sa, sc, ns, ng, ga, ps, vs);
        n_total++; if (sa !== 3 || ps !== ep) $display("FAIL ena_recover: got strobe_at=%0d pos=%0d expected 3/%0d", sa, ps, ep); else n_pass++;
        model_pos = ep; had_accept = 1'b1; last_accept_cyc = sc;
    endtask

    task automatic test_random;
        int high, low, sa, sc, ns, ng, ga, elapsed;
        logic [7:0] ps, ep;
        logic vs;
        bit acc, sh;
        for (int k = 0; k < 10; k++) begin
            high = $urandom_range(800*CPL, 100*CPL);
            low  = $urandom_range(200, 20);
            ref_decode(high, acc, sh, ep);
            drive_pulse(high, low, sa, sc, ns, ng, ga, ps, vs);
            if (acc) begin
                n_total++; if (sa !== 3 || ns !== 1 || ng !== 0) $display("FAIL rand_accept[%0d] high=%0d: got strobe_at=%0d strobes=%0d glitches=%0d expected 3/1/0", k, high, sa, ns, ng); else n_pass++;
                model_pos = ep; had_accept = 1'b1; last_accept_cyc = sc;
            end else begin
                n_total++; if (ns !== 0 || ng !== 1) $display("FAIL rand_reject[%0d] high=%0d: got strobes=%0d glitches=%0d expected 0/1", k, high, ns, ng); else n_pass++;
                if (sh) begin
                    n_total++; if (ga !== 3) $display("FAIL rand_reject_latency[%0d]: got %0d expected 3", k, ga); else n_pass++;
                end
            end
            n_total++; if (ps !== model_pos) $display("FAIL rand_pos[%0d] high=%0d: got %0d expected %0d", k, high, ps, model_pos); else n_pass++;
            elapsed = cyc - last_accept_cyc;
            if (had_accept && elapsed < (TO-1)*CPL - 4) begin
                n_total++; if (vs !== 1'b1) $display("FAIL rand_valid[%0d]: got %b expected 1", k, vs); else n_pass++;
            end else if (elapsed > (TO+2)*CPL) begin
                n_total++; if (vs !== 1'b0) $display("FAIL rand_valid_lost[%0d]: got %b expected 0", k, vs); else n_pass++;
            end
        end
    endtask

    task automatic test_timeout;
        int sa, sc, ns, ng, ga, waited;
        logic [7:0] ps, ep, exp_after;
        logic vs;
        bit acc, sh;
        ref_decode(2051, acc, sh, ep);
        drive_pulse(2051, 5, sa, sc, ns, ng, ga, ps, vs);
        model_pos = ep; had_accept = 1'b1; last_accept_cyc = sc;
        n_total++; if (sa !== 3 || ps !== 8'd255) $display("FAIL timeout_setup: got strobe_at=%0d pos=%0d expected 3/255", sa, ps); else n_pass++;
        while (cyc < sc + (TO-1)*CPL - 4) begin @(posedge clk); #1; end
        n_total++; if (bus.valid_o !== 1'b1) $display("FAIL timeout_early: got %b expected 1", bus.valid_o); else n_pass++;
        waited = 0;
        while (bus.valid_o === 1'b1 && waited < 4*CPL + 8) begin @(posedge clk); #1; waited++; end
        n_total++; if (bus.valid_o !== 1'b0) $display("FAIL timeout_drop: got %b expected 0 after %0d clks", bus.valid_o, waited); else n_pass++;
`ifdef RC_DEC_FAILSAFE_EN
        exp_after = 8'd128;
`else
        exp_after = model_pos;
`endif
        n_total++; if (bus.pos_o !== exp_after) $display("FAIL timeout_pos: got %0d expected %0d", bus.pos_o, exp_after); else n_pass++;
        model_pos = exp_after;
    endtask

    task automatic test_reset_mid_pulse;
        int ns, ng, sa, sc, ga;
        logic [7:0] ps, ep;
        logic vs;
        bit acc, sh;
        ns = 0; ng = 0;
        @(posedge clk); #1;
        bus.pwm_i = 1'b1;
        repeat (500) @(posedge clk);
        #20;
        rst_n = 1'b0;
        #1;
        n_total++; if (bus.pos_o !== 8'd0 || bus.valid_o !== 1'b0) $display("FAIL rstmid_async: got pos=%0d valid=%b expected 0/0", bus.pos_o, bus.valid_o); else n_pass++;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        model_pos = 8'd0; had_accept = 1'b0;
        for (int i = 0; i < 700; i++) begin
            @(posedge clk); #1;
            if (bus.strobe_o) ns++;
            if (bus.glitch_o) ng++;
        end
        bus.pwm_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.strobe_o) ns++;
            if (bus.glitch_o) ng++;
        end
        n_total++; if (ns !== 0 || ng !== 0) $display("FAIL rstmid_partial: got strobes=%0d glitches=%0d expected 0/0", ns, ng); else n_pass++;
        ref_decode(1538, acc, sh, ep);
        drive_pulse(1538, 40, sa, sc, ns, ng, ga, ps, vs);
        n_total++; if (sa !== 3 || ps !== ep || vs !== 1'b1) $display("FAIL rstmid_recover: got strobe_at=%0d pos=%0d valid=%b expected 3/%0d/1", sa, ps, vs, ep); else n_pass++;
    endtask

    initial begin
        bus.ena = 1'b1;
        bus.pwm_i = 1'b0;
        test_reset();
        test_nominal();
        test_boundaries();
        test_stuck_high();
        test_ena();
        test_random();
        test_timeout();
        test_reset_mid_pulse();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
